// File: rtl/seq_serializer_feed.sv
// rtl/seq_serializer_feed.sv - word FIFO plus bit shifter driving the sequence stage direction input
module seq_serializer_feed #(
    parameter int   DATA_W   = 8,
    parameter int   DEPTH    = 4,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        din,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic                     msb_first,
    output logic                     ser_out,
    output logic                     ser_valid,
    output logic                     word_done,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(DATA_W);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    logic [DATA_W:0]   mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [DATA_W-1:0] word_r, word_n;
    logic              msb_r, msb_n;
    logic [IW-1:0]     idx, idx_n, bit_sel;
    state_t            state, state_n;
    logic [DATA_W:0]   head;
    logic              push, pop, empty, last;
    logic              ser_out_n, ser_valid_n, word_done_n;

    assign din_ready = (level != FULL_LVL);
    assign push      = din_valid && din_ready;
    assign empty     = (level == '0);
    assign last      = (idx == LAST_IDX);
    assign head      = mem[rd_ptr];

    // A pop only ever looks at words already stored, never the same-edge push.
    always_comb begin
        pop     = 1'b0;
        state_n = state;
        word_n  = word_r;
        msb_n   = msb_r;
        idx_n   = idx;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = SHIFT;
                    word_n  = head[DATA_W-1:0];
                    msb_n   = head[DATA_W];
                    idx_n   = '0;
                end
            end
            SHIFT: begin
                if (last) begin
                    if (!empty) begin
                        pop    = 1'b1;
                        word_n = head[DATA_W-1:0];
                        msb_n  = head[DATA_W];
                        idx_n  = '0;
                    end else begin
                        state_n = IDLE;
                        idx_n   = '0;
                    end
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        bit_sel     = msb_n ? (LAST_IDX - idx_n) : idx_n;
        ser_valid_n = (state_n == SHIFT);
        ser_out_n   = (state_n == SHIFT) ? word_n[bit_sel] : IDLE_LVL;
        word_done_n = (state_n == SHIFT) && (idx_n == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            word_r    <= '0;
            msb_r     <= 1'b0;
            idx       <= '0;
            ser_out   <= IDLE_LVL;
            ser_valid <= 1'b0;
            word_done <= 1'b0;
        end else begin
            state     <= state_n;
            word_r    <= word_n;
            msb_r     <= msb_n;
            idx       <= idx_n;
            ser_out   <= ser_out_n;
            ser_valid <= ser_valid_n;
            word_done <= word_done_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    // Storage needs no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {msb_first, din};
    end

endmodule

// File: tb/tb_seq_serializer_feed.sv
// tb/tb_seq_serializer_feed.sv - directed bench for seq_serializer_feed
module tb_seq_serializer_feed;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       msb_first = 1'b1;
    logic       ser_out;
    logic       ser_valid;
    logic       word_done;
    logic [2:0] level;

    int checks = 0;
    int failures = 0;
    int max_level = 0;
    logic saw_low = 1'b0;
    logic bits_q[$];
    logic [7:0] word_buf [8];

    seq_serializer_feed #(.DATA_W(8), .DEPTH(4), .IDLE_LVL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .msb_first(msb_first), .ser_out(ser_out),
        .ser_valid(ser_valid), .word_done(word_done), .level(level)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ser_valid === 1'b1) bits_q.push_back(ser_out);
        if (int'(level) > max_level) max_level <= int'(level);
    end

    task automatic drive_words(input int first, input int cnt, input logic msb);
        int j = first;
        int budget = 0;
        logic r;
        msb_first = msb;
        while (j < first + cnt && budget < 100) begin
            din = word_buf[j];
            din_valid = 1'b1;
            r = din_ready;
            if (!r) saw_low = 1'b1;
            @(posedge clk); #1;
            if (r) j++;
            budget++;
        end
        din_valid = 1'b0;
        checks++;
        if (j !== first + cnt) begin
            failures++;
            $display("FAIL drive_words accepted=%0d required=%0d", j - first, cnt);
        end
    endtask

    task automatic wait_drain();
        int b = 0;
        while ((ser_valid !== 1'b0 || level !== 3'd0) && b < 300) begin
            @(posedge clk); #1;
            b++;
        end
        checks++;
        if (b >= 300) begin
            failures++;
            $display("FAIL drain_timeout ser_valid=%b level=%0d required idle", ser_valid, level);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (ser_out !== 1'b0)   begin failures++; $display("FAIL reset_ser_out got=%b exp=0", ser_out); end
        if (ser_valid !== 1'b0) begin failures++; $display("FAIL reset_ser_valid got=%b exp=0", ser_valid); end
        if (word_done !== 1'b0) begin failures++; $display("FAIL reset_word_done got=%b exp=0", word_done); end
        if (level !== 3'd0)     begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        if (din_ready !== 1'b1) begin failures++; $display("FAIL reset_din_ready got=%b exp=1", din_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_serialize(input logic [7:0] w, input logic msb, input logic [7:0] seq);
        din = w;
        msb_first = msb;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        checks += 2;
        if (ser_valid !== 1'b0) begin failures++; $display("FAIL ser_push_cycle_valid got=%b exp=0", ser_valid); end
        if (level !== 3'd1)     begin failures++; $display("FAIL ser_push_cycle_level got=%0d exp=1", level); end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks += 3;
            if (ser_out !== seq[7-i]) begin failures++; $display("FAIL ser_bit%0d w=%h msb=%b got=%b exp=%b", i, w, msb, ser_out, seq[7-i]); end
            if (ser_valid !== 1'b1)   begin failures++; $display("FAIL ser_valid%0d got=%b exp=1", i, ser_valid); end
            if (word_done !== (i == 7)) begin failures++; $display("FAIL ser_word_done%0d got=%b exp=%b", i, word_done, (i == 7)); end
        end
        @(posedge clk); #1;
        checks += 2;
        if (ser_valid !== 1'b0) begin failures++; $display("FAIL ser_after_valid got=%b exp=0", ser_valid); end
        if (ser_out !== 1'b0)   begin failures++; $display("FAIL ser_after_idle_lvl got=%b exp=0", ser_out); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq;
        seq = 16'b0000_1111_1111_0000;
        max_level = 0;
        msb_first = 1'b1;
        din = 8'h0F;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din = 8'hF0;
        @(posedge clk); #1;
        din_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            checks += 3;
            if (ser_valid !== 1'b1)    begin failures++; $display("FAIL b2b_valid%0d got=%b exp=1", i, ser_valid); end
            if (ser_out !== seq[15-i]) begin failures++; $display("FAIL b2b_bit%0d got=%b exp=%b", i, ser_out, seq[15-i]); end
            if (word_done !== (i == 7 || i == 15)) begin
                failures++; $display("FAIL b2b_word_done%0d got=%b exp=%b", i, word_done, (i == 7 || i == 15));
            end
        end
        @(posedge clk); #1;
        checks += 2;
        if (ser_valid !== 1'b0) begin failures++; $display("FAIL b2b_end_valid got=%b exp=0", ser_valid); end
        if (max_level !== 1)    begin failures++; $display("FAIL b2b_level_peak got=%0d exp=1", max_level); end
    endtask

    task automatic test_full_backpressure();
        word_buf[0] = 8'hA5; word_buf[1] = 8'h3C; word_buf[2] = 8'h81;
        word_buf[3] = 8'h7E; word_buf[4] = 8'h55; word_buf[5] = 8'hC3;
        max_level = 0;
        saw_low = 1'b0;
        bits_q.delete();
        drive_words(0, 6, 1'b1);
        wait_drain();
        checks += 3;
        if (max_level !== 4)   begin failures++; $display("FAIL full_level_peak got=%0d exp=4", max_level); end
        if (saw_low !== 1'b1)  begin failures++; $display("FAIL full_ready_drop got=%b exp=1", saw_low); end
        if (bits_q.size() !== 48) begin failures++; $display("FAIL full_bit_count got=%0d exp=48", bits_q.size()); end
        else begin
            for (int k = 0; k < 48; k++) begin
                checks++;
                if (bits_q[k] !== word_buf[k/8][7 - (k%8)]) begin
                    failures++; $display("FAIL full_stream bit%0d got=%b exp=%b", k, bits_q[k], word_buf[k/8][7 - (k%8)]);
                end
            end
        end
    endtask

    task automatic test_full_hold();
        int b = 0;
        word_buf[0] = 8'h11; word_buf[1] = 8'h22; word_buf[2] = 8'h33;
        word_buf[3] = 8'h44; word_buf[4] = 8'h55; word_buf[5] = 8'h96;
        bits_q.delete();
        drive_words(0, 5, 1'b1);
        checks += 2;
        if (level !== 3'd4)     begin failures++; $display("FAIL hold_full_level got=%0d exp=4", level); end
        if (din_ready !== 1'b0) begin failures++; $display("FAIL hold_full_ready got=%b exp=0", din_ready); end
        din = word_buf[5];
        din_valid = 1'b1;
        while (level === 3'd4 && b < 30) begin
            @(posedge clk); #1;
            b++;
        end
        checks += 2;
        if (level !== 3'd3)     begin failures++; $display("FAIL hold_pop_edge_level got=%0d exp=3", level); end
        if (din_ready !== 1'b1) begin failures++; $display("FAIL hold_pop_edge_ready got=%b exp=1", din_ready); end
        @(posedge clk); #1;
        din_valid = 1'b0;
        checks += 2;
        if (level !== 3'd4)     begin failures++; $display("FAIL hold_repush_level got=%0d exp=4", level); end
        if (din_ready !== 1'b0) begin failures++; $display("FAIL hold_repush_ready got=%b exp=0", din_ready); end
        wait_drain();
        checks++;
        if (bits_q.size() !== 48) begin failures++; $display("FAIL hold_bit_count got=%0d exp=48", bits_q.size()); end
        else begin
            for (int k = 0; k < 48; k++) begin
                checks++;
                if (bits_q[k] !== word_buf[k/8][7 - (k%8)]) begin
                    failures++; $display("FAIL hold_stream bit%0d got=%b exp=%b", k, bits_q[k], word_buf[k/8][7 - (k%8)]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_word();
        word_buf[0] = 8'hC1; word_buf[1] = 8'hC2; word_buf[2] = 8'hC3;
        drive_words(0, 3, 1'b1);
        checks++;
        if (level !== 3'd2) begin failures++; $display("FAIL midrst_buffered got=%0d exp=2", level); end
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        bits_q.delete();
        checks += 5;
        if (ser_out !== 1'b0)   begin failures++; $display("FAIL midrst_ser_out got=%b exp=0", ser_out); end
        if (ser_valid !== 1'b0) begin failures++; $display("FAIL midrst_ser_valid got=%b exp=0", ser_valid); end
        if (word_done !== 1'b0) begin failures++; $display("FAIL midrst_word_done got=%b exp=0", word_done); end
        if (level !== 3'd0)     begin failures++; $display("FAIL midrst_level got=%0d exp=0", level); end
        if (din_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", din_ready); end
        #20;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        checks += 2;
        if (bits_q.size() !== 0) begin failures++; $display("FAIL midrst_leftover_bits got=%0d exp=0", bits_q.size()); end
        if (level !== 3'd0)      begin failures++; $display("FAIL midrst_level_after got=%0d exp=0", level); end
        test_serialize(8'hB4, 1'b1, 8'b1011_0100);
    endtask

    initial begin
        #2;
        test_reset();
        @(posedge clk); #1;
        test_serialize(8'hB4, 1'b1, 8'b1011_0100);
        test_serialize(8'hB4, 1'b0, 8'b0010_1101);
        test_back_to_back();
        test_full_backpressure();
        test_full_hold();
        test_reset_mid_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_serializer_feed.md
Name: seq_serializer_feed

Overview:
- Upstream feeder for the 2-bit up/down sequence counter stage. Its serial output drives that stage's single-bit direction input A.
- Accepts parallel words over a valid/ready handshake and buffers them in a small FIFO.
- Emits each word one bit per clock, with no bubble between back-to-back words.
- Flags word boundaries so downstream logic can align the Y pulses to source words.

Parameters:
- DATA_W, 8: word width in bits; must be at least 2.
- DEPTH, 4: FIFO depth in words; must be a power of 2 and at least 2.
- IDLE_LVL, 1'b0: level driven on ser_out while no word is being shifted.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  DATA_W  parallel word to serialize.
- din_valid  input  1  din holds a valid word.
- din_ready  output  1  FIFO can accept a word this cycle.
- msb_first  input  1  bit order; sampled only when a word is pushed.
- ser_out  output  1  serial bit stream, feeding the sequence stage's A input.
- ser_valid  output  1  ser_out carries a data bit this cycle.
- word_done  output  1  high during the last bit of each word.
- level  output  log2(DEPTH)+1  number of words currently held in the FIFO, excluding the word in the shifter.

Behaviour:
- Reset (asynchronous, active-low):
  - ser_out=IDLE_LVL, ser_valid=0, word_done=0, level=0, din_ready=1.
  - FIFO pointers, shifter and bit counter are cleared.
  - Reset asserted mid-word aborts the word immediately; all buffered words are discarded.
- Push:
  - Occurs on an edge where din_valid && din_ready.
  - {msb_first, din} is written to the FIFO.
  - din_ready = (level != DEPTH), decoded from registered state only.
  - When full, a push is refused even if a pop happens on the same edge.
  - din_valid while din_ready=0 has no effect; the source must hold the word.
- Shifter states:
  - IDLE: ser_valid=0, ser_out=IDLE_LVL.
    - If the FIFO is non-empty at an edge: pop the head, load it, go to SHIFT, bit index=0.
  - SHIFT: ser_out = word[DATA_W-1-idx] when msb_first=1, else word[idx]; ser_valid=1.
    - idx increments each edge.
    - On the edge where idx=DATA_W-1:
      - FIFO non-empty: pop the next word and reload, idx=0, stay in SHIFT. No gap cycle.
      - FIFO empty: go to IDLE.
- Outputs ser_out, ser_valid and word_done are registered.
- word_done=1 exactly during the cycle in which bit DATA_W-1 is presented.
- Latency: with the shifter IDLE and the FIFO empty, a word pushed at edge k is popped at edge k+1. Its first bit is on ser_out from edge k+1 to edge k+2. A word occupies DATA_W consecutive cycles.
- Push and pop on the same edge: level is unchanged; a pop does not depend on the same-edge push.
- level increments on push-only and decrements on pop-only; it never exceeds DEPTH and never goes below 0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are derived from level.

Test Plan:
- Reset, then push 8'hB4 with msb_first=1. Required: ser_out reads 1,0,1,1,0,1,0,0 on 8 consecutive cycles; ser_valid=1 throughout; word_done on the 8th cycle only; then ser_out=IDLE_LVL and ser_valid=0.
- Same word 8'hB4 with msb_first=0. Required: ser_out reads 0,0,1,0,1,1,0,1.
- Push 8'h0F then 8'hF0 on back-to-back cycles. Required: 16 contiguous ser_valid cycles with no gap; word_done on cycles 8 and 16; level peaks at 1.
- Push 6 words with din_valid held high and DEPTH=4. Required: din_ready drops once 4 words are buffered, refused words are not lost, level reaches 4 and never 5, and all 6 words appear in order.
- Push 4 words to fill the FIFO, then hold din_valid=1 across the pop edge. Required: no push on that edge while din_ready=0; the push happens the next cycle and level returns to 4.
- Pull rst_n low at bit 3 of a word with 2 words buffered. Required: outputs go to reset values immediately, level=0, no remaining bits emitted after release, and the next pushed word serializes correctly from its bit 0.
